// File: rtl/c1541_track_ctl.sv
// Track buffer controller: debounces head steps, writes back a modified track,
// then loads the requested track sector by sector over the SD block interface.
module c1541_track_ctl #(
  parameter int SETTLE_CYCLES = 32000
) (
  input  logic       clk32,
  input  logic       reset,
  input  logic [5:0] track,
  input  logic       img_mounted,
  input  logic       img_readonly,
  input  logic       ram_we,
  output logic       ram_ready,
  output logic [5:0] cur_track,
  output logic       dirty,
  output logic       busy,
  output logic [9:0] sd_lba,
  output logic [4:0] buff_sector,
  output logic       sd_rd,
  output logic       sd_wr,
  input  logic       sd_ack
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, SAVE, LOAD} state_t;

  state_t        state, next_state;
  logic          valid, reload, abort, req;
  logic [5:0]    target, trk_n, xfer_track;
  logic [CW-1:0] settle_cnt;
  logic [4:0]    sector;
  logic          settle_done, last, xfer_free, abort_now;

  function automatic logic [4:0] track_spt(input logic [5:0] t);
    if (t <= 6'd17)      return 5'd21;
    else if (t <= 6'd24) return 5'd19;
    else if (t <= 6'd30) return 5'd18;
    else                 return 5'd17;
  endfunction

  function automatic logic [9:0] track_base(input logic [5:0] t);
    logic [9:0] tw;
    tw = {4'd0, t};
    if (t <= 6'd18)      return (tw - 10'd1) * 10'd21;
    else if (t <= 6'd25) return 10'd357 + (tw - 10'd18) * 10'd19;
    else if (t <= 6'd31) return 10'd490 + (tw - 10'd25) * 10'd18;
    else                 return 10'd598 + (tw - 10'd31) * 10'd17;
  endfunction

  assign trk_n       = (track == 6'd0) ? 6'd1 : track;
  assign xfer_track  = (state == SAVE) ? cur_track : target;
  assign settle_done = (settle_cnt == CW'(SETTLE_CYCLES));
  assign last        = (sector == track_spt(xfer_track) - 5'd1);
  // A request in flight must see its ack before the FSM may leave SAVE/LOAD.
  assign xfer_free   = !req || sd_ack;
  assign abort_now   = abort || img_mounted || (state == LOAD && trk_n != target);

  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    // NOTE: default first so every path assigns next_state and no latch is inferred.
    next_state = state;
    unique case (state)
      IDLE:
        if (valid && (trk_n != cur_track || reload)) next_state = SETTLE;
      SETTLE:
        if (!img_mounted && trk_n == target && settle_done)
          next_state = (dirty && !img_readonly) ? SAVE : LOAD;
      SAVE:
        if (abort_now && xfer_free)      next_state = SETTLE;
        else if (req && sd_ack && last)  next_state = (trk_n != target) ? SETTLE : LOAD;
      LOAD:
        if (abort_now && xfer_free)      next_state = SETTLE;
        else if (req && sd_ack && last)  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      valid      <= 1'b0;
      reload     <= 1'b0;
      abort      <= 1'b0;
      req        <= 1'b0;
      dirty      <= 1'b0;
      cur_track  <= 6'h3F;
      target     <= 6'd1;
      settle_cnt <= '0;
      sector     <= 5'd0;
    end else begin
      // NOTE: non-blocking everywhere here so every branch sees pre-edge values.
      if (img_mounted) valid <= 1'b1;

      if (img_mounted)                                reload <= 1'b1;
      else if (state == LOAD && next_state == IDLE)   reload <= 1'b0;

      // A fresh image discards pending write-back, even against a same-cycle write.
      if (img_mounted)                                dirty <= 1'b0;
      else if (state == SAVE && next_state != SAVE)   dirty <= 1'b0;
      else if (ram_we && ram_ready && !img_readonly)  dirty <= 1'b1;

      if (state == LOAD && next_state == IDLE) cur_track <= target;

      if (next_state == SETTLE && (state != SETTLE || trk_n != target || img_mounted)) begin
        target     <= trk_n;
        settle_cnt <= '0;
      end else if (state == SETTLE && !settle_done) begin
        settle_cnt <= settle_cnt + CW'(1);
      end

      if (next_state != state) begin
        abort  <= 1'b0;
        req    <= (next_state == SAVE || next_state == LOAD);
        sector <= 5'd0;
      end else if (state == SAVE || state == LOAD) begin
        abort <= abort_now;
        if (req && sd_ack) begin
          req    <= 1'b0;
          sector <= sector + 5'd1;
        end else if (!req) begin
          req <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    busy        = (state == SAVE) || (state == LOAD);
    ram_ready   = (state == IDLE) && valid && (trk_n == cur_track) && !reload;
    sd_wr       = (state == SAVE) && req;
    sd_rd       = (state == LOAD) && req;
    buff_sector = sector;
    sd_lba      = busy ? track_base(xfer_track) + {5'd0, sector} : 10'd0;
  end

endmodule

// File: doc/c1541_track_ctl.md
# c1541_track_ctl

Track buffer controller for the 1541 drive model. It sequences whole-track transfers between the mounted D64 image (via a sector-granular SD block interface) and the track buffer RAM that the GCR read/write engine streams from. It debounces head-step track changes and writes back a modified track before loading the next one. It gates the GCR engine with `ram_ready` so the engine never reads a partially loaded buffer.

## Interface
Parameters:
- `SETTLE_CYCLES`, 32000: clk32 cycles the requested track must stay stable before a transfer starts (1 ms at 32 MHz).

Ports:
- `clk32` in 1: system clock, 32 MHz.
- `reset` in 1: asynchronous, active-high reset.
- `track` in 6: track requested by drive logic, 1..42; 0 is treated as 1.
- `img_mounted` in 1: one-cycle pulse; a new image is present and any pending write-back is discarded.
- `img_readonly` in 1: level; when 1, write-back is suppressed and `dirty` never sets.
- `ram_we` in 1: write strobe from the GCR engine into the track buffer.
- `ram_ready` out 1: buffer holds the valid, fully loaded `cur_track`.
- `cur_track` out 6: track currently held in the buffer.
- `dirty` out 1: buffer modified since load.
- `busy` out 1: a save or load is in progress.
- `sd_lba` out 10: D64 sector index (256-byte units) of the current request.
- `buff_sector` out 5: buffer sector slot (0..20) for the current request.
- `sd_rd` out 1: read request, image to buffer.
- `sd_wr` out 1: write request, buffer to image.
- `sd_ack` in 1: one-cycle pulse; the requested sector transfer is complete.

## Operation
- Sectors per track: 21 for tracks 1–17, 19 for 18–24, 18 for 25–30, 17 for 31–42.
- Track base LBA (10-bit, no overflow up to track 42):
  - t≤18: (t-1)·21
  - t≤25: 357+(t-18)·19
  - t≤31: 490+(t-25)·18
  - else: 598+(t-31)·17
- `sd_lba` = base(`cur_track` for save, target for load) + `buff_sector`.
- Internal `valid` flag: set by `img_mounted`, cleared by reset.
- States:
  - IDLE: if `valid` and (`track`≠`cur_track` or reload pending), go to SETTLE and latch the target.
  - SETTLE: count to SETTLE_CYCLES. A `track` change restarts the count with the new target. When done, go to SAVE if `dirty` and not `img_readonly`, else LOAD.
  - SAVE: for s=0..spt(`cur_track`)-1, assert `sd_wr` and wait for `sd_ack`. After the last sector, clear `dirty` and go to LOAD.
  - LOAD: for s=0..spt(target)-1, assert `sd_rd` and wait for `sd_ack`. After the last sector, set `cur_track`=target and go to IDLE.
- `ram_ready`=1 only in IDLE with `valid` and no pending change. It drops on the cycle IDLE→SETTLE.
- `dirty` sets on `ram_we`&`ram_ready`&~`img_readonly`. `ram_we` while not ready is ignored.
- `busy`=1 in SAVE and LOAD.
- Boundary rules:
  - Track change during SAVE: the save of `cur_track` completes in full (no data loss), then the FSM returns to SETTLE with the newest target.
  - Track change during LOAD: the current sector finishes, then SETTLE restarts and `cur_track` is unchanged.
  - `img_mounted` in any state: clear `dirty`, set reload pending, go to SETTLE after any outstanding `sd_ack` (the request is not withdrawn mid-transfer). It is valid even when `track`==`cur_track`.
  - `img_mounted` coincident with `ram_we`: clearing wins.
  - `sd_ack` outside a request is ignored.

## Timing
- Reset values:
  - `ram_ready`, `dirty`, `busy`, `sd_rd`, `sd_wr`: 0
  - `sd_lba`, `buff_sector`: 0
  - `cur_track`: 6'h3F (invalid, forces the first load)
  - `valid`: 0, FSM in IDLE
- Request handshake: `sd_rd`/`sd_wr` rise with `sd_lba` and `buff_sector` valid on the same edge. All three are held stable until the `sd_ack` cycle and drop on the following edge.
- Next-sector request is asserted one cycle after the previous `sd_ack`.
- Never both `sd_rd` and `sd_wr` at once.
- Track change to transfer start: SETTLE_CYCLES+1 cycles after the last `track` change.
- `ram_ready` rises one cycle after the final load `sd_ack`.

## Test plan
- Mount, `track`=18, `sd_ack` after each request → 19 reads, `sd_lba` 357..375, `buff_sector` 0..18, then `ram_ready`=1 and `cur_track`=18.
- At track 18, pulse `ram_we`, step to 19 → 19 writes at LBA 357..375, then 19 reads at LBA 376..394, `dirty`=0 at end.
- Same as above with `img_readonly`=1 → no `sd_wr`, only reads.
- Toggle `track` 18→19→20 at intervals < SETTLE_CYCLES → no request until stable at 20, then a single load at LBA 395.
- `track` change mid-SAVE at sector 5 → all 19 writes issued, then load of the new track.
- `img_mounted` during LOAD sector 3 → sector 3 ack completes, `dirty`=0, full reload of the same track from sector 0; reset asserted mid-LOAD → all outputs return to reset values immediately.
